// File: rtl/intr_gateway.sv
// Per-source interrupt gateway: IDLE/PENDING/CLAIMED FSM per source with level or edge capture.
// Define INTR_GATEWAY_EDGE_EN to add the le_i port, edge detection and one deferred edge per source.
module intr_gateway #(
  parameter int N = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] src_i,
`ifdef INTR_GATEWAY_EDGE_EN
  input  logic [N-1:0] le_i,
`endif
  input  logic [N-1:0] claim_i,
  input  logic [N-1:0] complete_i,
  output logic [N-1:0] ip_o,
  output logic [N-1:0] busy_o,
  output logic         irq_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_CLAIMED = 2'd2
  } state_t;

  state_t       r_state [N];
  logic [N-1:0] r_ip;
  logic [N-1:0] r_busy;
  logic [N-1:0] w_req;
  logic [N-1:0] w_rearm;

`ifdef INTR_GATEWAY_EDGE_EN
  logic [N-1:0] r_src_q;
  logic [N-1:0] r_deferred;
  logic [N-1:0] w_edge;

  assign w_edge  = le_i & src_i & ~r_src_q;
  assign w_req   = w_edge | (~le_i & src_i);
  // An edge coincident with completion counts as deferred.
  assign w_rearm = r_deferred | w_edge;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_src_q    <= '0;
      r_deferred <= '0;
    end else begin
      r_src_q <= src_i;
      for (int i = 0; i < N; i++) begin
        if (r_state[i] == S_CLAIMED) begin
          if (complete_i[i]) begin
            r_deferred[i] <= 1'b0;
          end else if (w_edge[i]) begin
            r_deferred[i] <= 1'b1;
          end
        end
      end
    end
  end
`else
  assign w_req   = src_i;
  assign w_rearm = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= S_IDLE;
      end
      r_ip   <= '0;
      r_busy <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        case (r_state[i])
          S_IDLE: begin
            if (w_req[i]) begin
              r_state[i] <= S_PENDING;
              r_ip[i]    <= 1'b1;
            end
          end
          S_PENDING: begin
            // Claim wins over a simultaneous complete; later edges merge here.
            if (claim_i[i]) begin
              r_state[i] <= S_CLAIMED;
              r_ip[i]    <= 1'b0;
              r_busy[i]  <= 1'b1;
            end
          end
          S_CLAIMED: begin
            if (complete_i[i]) begin
              r_busy[i] <= 1'b0;
              if (w_rearm[i]) begin
                r_state[i] <= S_PENDING;
                r_ip[i]    <= 1'b1;
              end else begin
                r_state[i] <= S_IDLE;
              end
            end
          end
          default: begin
            r_state[i] <= S_IDLE;
            r_ip[i]    <= 1'b0;
            r_busy[i]  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ip_o   = r_ip;
  assign busy_o = r_busy;
  assign irq_o  = |r_ip;

endmodule

// File: tb/tb_intr_gateway.sv
// Self-checking bench for intr_gateway (N=2) against a rule-level model of the gateway.
module tb_intr_gateway;

  localparam int N = 2;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] src;
  logic [N-1:0] le;
  logic [N-1:0] claim;
  logic [N-1:0] complete;
  logic [N-1:0] ip;
  logic [N-1:0] busy;
  logic         irq;

  int n_pass;
  int n_total;

  // Model: per-source "waiting for service" and "being serviced" flags.
  bit m_pend  [N];
  bit m_serv  [N];
  bit m_def   [N];
  bit m_prev  [N];

  intr_gateway #(.N(N)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .src_i      (src),
`ifdef INTR_GATEWAY_EDGE_EN
    .le_i       (le),
`endif
    .claim_i    (claim),
    .complete_i (complete),
    .ip_o       (ip),
    .busy_o     (busy),
    .irq_o      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic bit edge_mode(int i);
`ifdef INTR_GATEWAY_EDGE_EN
    return le[i];
`else
    return 1'b0 && (i >= 0);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0;
      m_serv[i] = 0;
      m_def[i]  = 0;
      m_prev[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      bit em;
      bit rise;
      bit req;
      em   = edge_mode(i);
      rise = em && src[i] && !m_prev[i];
      req  = em ? rise : src[i];
      if (m_pend[i]) begin
        if (claim[i]) begin
          m_pend[i] = 0;
          m_serv[i] = 1;
        end
      end else if (m_serv[i]) begin
        if (complete[i]) begin
          m_serv[i] = 0;
          m_pend[i] = m_def[i] || rise;
          m_def[i]  = 0;
        end else if (rise) begin
          m_def[i] = 1;
        end
      end else if (req) begin
        m_pend[i] = 1;
      end
      m_prev[i] = src[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  function automatic logic [N-1:0] m_ip_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic [N-1:0] m_busy_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_serv[i];
    return v;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    src = '0; claim = '0; complete = '0; le = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_total++;
    if (ip !== 2'b00 || busy !== 2'b00 || irq !== 1'b0)
      $display("FAIL reset_state: got ip=%b busy=%b irq=%b, required 00 00 0", ip, busy, irq);
    else n_pass++;
  endtask

  task automatic test_level_basic();
    apply_reset();
    src = 2'b01;
    tick();
    n_total++;
    if (ip !== 2'b01 || irq !== 1'b1 || busy !== 2'b00)
      $display("FAIL level_pend: got ip=%b irq=%b busy=%b, required 01 1 00", ip, irq, busy);
    else n_pass++;
    tick();
    tick();
    claim = 2'b01;
    tick();
    claim = 2'b00;
    n_total++;
    if (ip !== 2'b00 || busy !== 2'b01 || irq !== 1'b0)
      $display("FAIL level_claim: got ip=%b busy=%b irq=%b, required 00 01 0", ip, busy, irq);
    else n_pass++;
    tick();
    complete = 2'b01;
    tick();
    complete = 2'b00;
    n_total++;
    if (busy !== 2'b00 || ip !== 2'b00)
      $display("FAIL level_complete: got busy=%b ip=%b, required 00 00", busy, ip);
    else n_pass++;
    tick();
    n_total++;
    if (ip !== 2'b01 || irq !== 1'b1)
      $display("FAIL level_rearm: got ip=%b irq=%b, required 01 1", ip, irq);
    else n_pass++;
  endtask

  task automatic test_claim_complete_together();
    apply_reset();
    src = 2'b01;
    tick();
    src = 2'b00;
    claim = 2'b01;
    complete = 2'b01;
    tick();
    claim = 2'b00;
    complete = 2'b00;
    n_total++;
    if (busy !== 2'b01 || ip !== 2'b00)
      $display("FAIL claim_wins: got busy=%b ip=%b, required 01 00", busy, ip);
    else n_pass++;
    // Stray claim in CLAIMED and complete in IDLE on the other source are ignored.
    claim = 2'b01;
    complete = 2'b10;
    tick();
    claim = 2'b00;
    complete = 2'b00;
    n_total++;
    if (busy !== 2'b01 || ip !== 2'b00)
      $display("FAIL ignored_strobes: got busy=%b ip=%b, required 01 00", busy, ip);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    src = 2'b10;
    tick();
    src = 2'b00;
    claim = 2'b10;
    tick();
    claim = 2'b00;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (busy !== 2'b00 || ip !== 2'b00 || irq !== 1'b0)
      $display("FAIL async_reset: got busy=%b ip=%b irq=%b, required 00 00 0", busy, ip, irq);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    n_total++;
    if (ip !== 2'b00 || busy !== 2'b00)
      $display("FAIL post_reset_idle: got ip=%b busy=%b, required 00 00", ip, busy);
    else n_pass++;
    // Level source held high across reset release pends on the first edge.
    @(negedge clk);
    rst_n = 1'b0;
    src = 2'b01;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick();
    n_total++;
    if (ip !== 2'b01)
      $display("FAIL release_level_high: got ip=%b, required 01", ip);
    else n_pass++;
  endtask

`ifdef INTR_GATEWAY_EDGE_EN
  task automatic test_edge_deferred();
    apply_reset();
    le = 2'b11;
    src = 2'b10;
    tick();
    src = 2'b00;
    n_total++;
    if (ip !== 2'b10)
      $display("FAIL edge_pend: got ip=%b, required 10", ip);
    else n_pass++;
    claim = 2'b10;
    tick();
    claim = 2'b00;
    src = 2'b10; tick();
    src = 2'b00; tick();
    src = 2'b10; tick();
    src = 2'b00; tick();
    n_total++;
    if (busy !== 2'b10 || ip !== 2'b00)
      $display("FAIL edge_hold: got busy=%b ip=%b, required 10 00", busy, ip);
    else n_pass++;
    complete = 2'b10;
    tick();
    complete = 2'b00;
    n_total++;
    if (ip !== 2'b10 || busy !== 2'b00)
      $display("FAIL edge_repend: got ip=%b busy=%b, required 10 00", ip, busy);
    else n_pass++;
    claim = 2'b10; tick(); claim = 2'b00;
    complete = 2'b10; tick(); complete = 2'b00;
    tick();
    n_total++;
    if (ip !== 2'b00 || busy !== 2'b00)
      $display("FAIL edge_single_repend: got ip=%b busy=%b, required 00 00", ip, busy);
    else n_pass++;
    // Edge coincident with complete re-pends.
    src = 2'b01; tick(); src = 2'b00;
    claim = 2'b01; tick(); claim = 2'b00;
    src = 2'b01; complete = 2'b01; tick();
    src = 2'b00; complete = 2'b00;
    n_total++;
    if (ip !== 2'b01 || busy !== 2'b00)
      $display("FAIL edge_with_complete: got ip=%b busy=%b, required 01 00", ip, busy);
    else n_pass++;
    // Held-high edge source at reset release gives exactly one edge.
    @(negedge clk);
    rst_n = 1'b0;
    src = 2'b10;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick();
    claim = 2'b10; tick(); claim = 2'b00;
    complete = 2'b10; tick(); complete = 2'b00;
    tick();
    n_total++;
    if (ip !== 2'b00 || busy !== 2'b00)
      $display("FAIL edge_release_once: got ip=%b busy=%b, required 00 00", ip, busy);
    else n_pass++;
    src = 2'b00;
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      src      = N'($urandom_range(0, 3));
      claim    = N'($urandom_range(0, 3) & $urandom_range(0, 3));
      complete = N'($urandom_range(0, 3) & $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) le = N'($urandom_range(0, 3));
      tick();
      n_total++;
      if (ip !== m_ip_vec() || busy !== m_busy_vec() || irq !== (|m_ip_vec()))
        $display("FAIL random_cycle_%0d: got ip=%b busy=%b irq=%b, required %b %b %b",
                 c, ip, busy, irq, m_ip_vec(), m_busy_vec(), |m_ip_vec());
      else n_pass++;
    end
    src = '0; claim = '0; complete = '0;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    src = '0; le = '0; claim = '0; complete = '0;
    model_reset();
    test_reset();
    test_level_basic();
    test_claim_complete_together();
    test_async_reset();
`ifdef INTR_GATEWAY_EDGE_EN
    test_edge_deferred();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
